// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
//   Shared types and sizes for the conv_job_controller slice.
//   - state_e : job sequencer states
//   - mode_e  : job mode as carried on cmd_mode
//   - N_A/N_B : byte counts of the 4x4 A and 3x3 B operands
//   - LOAD_BYTES : total bytes streamed in per job (A then B)
//   - N_C     : result bytes streamed out per job
// ---------------------------------------------------------------------------
package conv_pkg;

    localparam int unsigned N_A        = 16;
    localparam int unsigned N_B        = 9;
    localparam int unsigned LOAD_BYTES = N_A + N_B;
    localparam int unsigned N_C        = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE,
        RUN,
        WAIT_C,
        OUT
    } state_e;

    typedef enum logic [1:0] {
        MODE_STORE  = 2'd0,
        MODE_SINGLE = 2'd1,
        MODE_SA3    = 2'd2,
        MODE_SA2    = 2'd3
    } mode_e;

endpackage

// File: rtl/conv_load_regfile.sv
// ---------------------------------------------------------------------------
// conv_load_regfile
//   25 x 8-bit operand store filled sequentially from the load byte stream.
//   Bytes 0..15 are A (row-major), bytes 16..24 are B (row-major).
//   Contents persist until overwritten by the next job's load; only reset
//   clears them.
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   i_clear    in   rewind the write pointer to byte 0 (new job accepted)
//   i_wr_en    in   write i_wr_data at the pointer and advance
//   i_wr_data  in   8-bit load byte
//   o_last     out  pointer is at the final byte (index LOAD_BYTES-1)
//   o_a_flat   out  A bytes, a(r,c) at [8k+7:8k], k=(r-1)*4+(c-1)
//   o_b_flat   out  B bytes, b(r,c) at [8k+7:8k], k=(r-1)*3+(c-1)
// ---------------------------------------------------------------------------
module conv_load_regfile
    import conv_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic               i_wr_en,
    input  logic [7:0]         i_wr_data,
    output logic               o_last,
    output logic [8*N_A-1:0]   o_a_flat,
    output logic [8*N_B-1:0]   o_b_flat
);

    localparam int unsigned PTR_W = $clog2(LOAD_BYTES);

    logic [7:0]       r_mem [LOAD_BYTES];
    logic [PTR_W-1:0] r_ptr;

    assign o_last = (r_ptr == PTR_W'(LOAD_BYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
            for (int unsigned k = 0; k < LOAD_BYTES; k++) begin
                r_mem[k] <= '0;
            end
        end else begin
            if (i_clear) begin
                r_ptr <= '0;
            end else if (i_wr_en) begin
                r_mem[r_ptr] <= i_wr_data;
                // Pointer parks on the last byte; the controller leaves LOAD there.
                if (!o_last) begin
                    r_ptr <= r_ptr + 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_a_flat = '0;
        o_b_flat = '0;
        for (int unsigned k = 0; k < N_A; k++) begin
            o_a_flat[8*k +: 8] = r_mem[k];
        end
        for (int unsigned k = 0; k < N_B; k++) begin
            o_b_flat[8*k +: 8] = r_mem[N_A + k];
        end
    end

endmodule

// File: rtl/conv_job_controller.sv
// ---------------------------------------------------------------------------
// conv_job_controller
//   Job sequencer for the convolution compute datapath (4x4 A, 3x3 B ->
//   2x2 C, 8-bit). Accepts a job command, loads A/B from a byte stream,
//   requests a store, then the selected run, waits for the result and
//   streams c11, c12, c21, c22 out.
//
// Build option
//   CONV_TIMEOUT_EN : when defined, a watchdog aborts STORE/RUN/WAIT_C after
//                     TIMEOUT_CYCLES cycles without progress and sets the
//                     sticky err_timeout flag. Undefined: waits forever,
//                     err_timeout is constant 0.
//
// Parameters
//   TIMEOUT_CYCLES  watchdog limit in cycles (used with CONV_TIMEOUT_EN)
//
// Ports
//   clk, rst                       clock; asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_mode   job request (mode 0 store, 1 single,
//                                  2 sa3, 3 sa2); ready only in IDLE
//   in_valid/in_ready/in_data      25 load bytes, A row-major then B
//   a_flat, b_flat                 loaded operands to the datapath
//   active_store/_single/_sa3/_sa2 level requests, at most one high
//   done_store/done_single/
//   single_sa3/single_sa2          acknowledges for the above
//   computation_done, c11..c22     result valid and result bytes
//   out_valid/out_ready/out_data   4 result bytes, c11 first
//   busy                           not IDLE
//   err_timeout                    sticky watchdog flag
// ---------------------------------------------------------------------------
module conv_job_controller
    import conv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    output logic [8*N_A-1:0]   a_flat,
    output logic [8*N_B-1:0]   b_flat,
    output logic               active_store,
    output logic               active_single,
    output logic               active_sa3,
    output logic               active_sa2,
    input  logic               done_store,
    input  logic               done_single,
    input  logic               single_sa3,
    input  logic               single_sa2,
    input  logic               computation_done,
    input  logic [7:0]         c11,
    input  logic [7:0]         c12,
    input  logic [7:0]         c21,
    input  logic [7:0]         c22,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_data,
    output logic               busy,
    output logic               err_timeout
);

    state_e              r_state;
    state_e              w_state_adv;
    state_e              w_state_next;
    mode_e               r_mode;
    logic [N_C-1:0][7:0] r_c;
    logic [1:0]          r_out_idx;

    logic w_cmd_fire;
    logic w_in_fire;
    logic w_load_last;
    logic w_run_ack;
    logic w_capture;
    logic w_to_hit;

    assign w_cmd_fire = cmd_valid && (r_state == IDLE);
    assign w_in_fire  = in_valid && (r_state == LOAD);

    conv_load_regfile u_load_regfile (
        .clk       (clk),
        .rst_n     (rst),
        .i_clear   (w_cmd_fire),
        .i_wr_en   (w_in_fire),
        .i_wr_data (in_data),
        .o_last    (w_load_last),
        .o_a_flat  (a_flat),
        .o_b_flat  (b_flat)
    );

    // Only the ack belonging to the latched mode can end RUN.
    always_comb begin
        w_run_ack = 1'b0;
        case (r_mode)
            MODE_SINGLE: w_run_ack = done_single;
            MODE_SA3:    w_run_ack = single_sa3;
            MODE_SA2:    w_run_ack = single_sa2;
            default:     w_run_ack = 1'b0;
        endcase
    end

    // Natural next state (no watchdog) and result capture strobe.
    always_comb begin
        w_state_adv = r_state;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_state_adv = LOAD;
                end
            end
            LOAD: begin
                if (w_in_fire && w_load_last) begin
                    w_state_adv = STORE;
                end
            end
            STORE: begin
                if (done_store) begin
                    w_state_adv = (r_mode == MODE_STORE) ? IDLE : RUN;
                end
            end
            RUN: begin
                if (w_run_ack) begin
                    if (computation_done) begin
                        w_capture   = 1'b1;
                        w_state_adv = OUT;
                    end else begin
                        w_state_adv = WAIT_C;
                    end
                end
            end
            WAIT_C: begin
                if (computation_done) begin
                    w_capture   = 1'b1;
                    w_state_adv = OUT;
                end
            end
            OUT: begin
                if (out_ready && (r_out_idx == 2'(N_C - 1))) begin
                    w_state_adv = IDLE;
                end
            end
            default: w_state_adv = IDLE;
        endcase
    end

`ifdef CONV_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;
    logic            w_waiting;

    assign w_waiting = (r_state == STORE) || (r_state == RUN) || (r_state == WAIT_C);
    // The watchdog only fires when the waiting state would otherwise hold.
    assign w_to_hit  = w_waiting && (w_state_adv == r_state)
                       && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_state_next != r_state) begin
                r_to_cnt <= '0;
            end else if (w_waiting) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_cmd_fire) begin
                r_err <= 1'b0;
            end else if (w_to_hit) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_timeout = r_err;
`else
    assign w_to_hit    = 1'b0;
    assign err_timeout = 1'b0;

    // Parameter stays in the interface so overrides are legal in both builds.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_param_unused
    end
`endif

    assign w_state_next = w_to_hit ? IDLE : w_state_adv;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode    <= MODE_STORE;
            r_c       <= '0;
            r_out_idx <= '0;
        end else begin
            if (w_cmd_fire) begin
                r_mode <= mode_e'(cmd_mode);
            end
            if (w_capture) begin
                r_c       <= {c22, c21, c12, c11};
                r_out_idx <= '0;
            end else if ((r_state == OUT) && out_ready) begin
                r_out_idx <= r_out_idx + 1'b1;
            end
        end
    end

    // Outputs decode the state register only, so requests change exactly on
    // state transitions and drop with an asynchronous reset.
    always_comb begin
        cmd_ready     = 1'b0;
        in_ready      = 1'b0;
        active_store  = 1'b0;
        active_single = 1'b0;
        active_sa3    = 1'b0;
        active_sa2    = 1'b0;
        out_valid     = 1'b0;
        busy          = 1'b1;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            LOAD:  in_ready     = 1'b1;
            STORE: active_store = 1'b1;
            RUN: begin
                case (r_mode)
                    MODE_SINGLE: active_single = 1'b1;
                    MODE_SA3:    active_sa3    = 1'b1;
                    MODE_SA2:    active_sa2    = 1'b1;
                    default:     ;
                endcase
            end
            OUT:     out_valid = 1'b1;
            default: ;
        endcase
    end

    assign out_data = r_c[r_out_idx];

endmodule

// File: tb/tb_conv_job_controller.sv
`timescale 1ns/1ps
module tb_conv_job_controller;

`ifdef CONV_TIMEOUT_EN
    localparam int unsigned TO_CYC = 16;
`else
    localparam int unsigned TO_CYC = 1024;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_mode = 2'd0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_data = 8'd0;
    logic [127:0] a_flat;
    logic [71:0]  b_flat;
    logic         active_store, active_single, active_sa3, active_sa2;
    logic         done_store = 1'b0, done_single = 1'b0;
    logic         single_sa3 = 1'b0, single_sa2 = 1'b0;
    logic         computation_done = 1'b0;
    logic [7:0]   c11 = 8'd0, c12 = 8'd0, c21 = 8'd0, c22 = 8'd0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [7:0]   out_data;
    logic         busy;
    logic         err_timeout;

    always #5 clk = ~clk;

    conv_job_controller #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .a_flat(a_flat), .b_flat(b_flat),
        .active_store(active_store), .active_single(active_single),
        .active_sa3(active_sa3), .active_sa2(active_sa2),
        .done_store(done_store), .done_single(done_single),
        .single_sa3(single_sa3), .single_sa2(single_sa2),
        .computation_done(computation_done),
        .c11(c11), .c12(c12), .c21(c21), .c22(c22),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .err_timeout(err_timeout)
    );

    typedef struct {
        logic [1:0]      mode;
        int unsigned     ds_dly;   // idle cycles in STORE before done_store
        int unsigned     ack_dly;  // idle cycles in RUN before the mode ack
        int unsigned     cd_dly;   // 0: computation_done together with ack
        logic [7:0]      base;     // load bytes are base, base+1, ...
        logic [3:0][7:0] c;        // c[0]=c11 .. c[3]=c22
        logic [7:0]      rdy_pat;  // out_ready pattern, LSB first, repeating
        bit              stray;    // drive unrelated acks / computation_done
    } job_t;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [3:0] run_onehot(input logic [1:0] m);
        return 4'b0001 << m;
    endfunction

    task automatic chk_act(input string name, input logic [3:0] exp);
        chk(name, {active_sa2, active_sa3, active_single, active_store}, exp);
    endtask

    task automatic set_c(input logic [3:0][7:0] v);
        c11 = v[0]; c12 = v[1]; c21 = v[2]; c22 = v[3];
    endtask

    task automatic clear_acks();
        done_store = 1'b0; done_single = 1'b0; single_sa3 = 1'b0; single_sa2 = 1'b0;
        computation_done = 1'b0;
        set_c({4{8'h5A}});
    endtask

    task automatic exp_flat(input logic [7:0] base, output logic [127:0] ea, output logic [71:0] eb);
        ea = '0;
        eb = '0;
        for (int k = 0; k < 16; k++) ea[8*k +: 8] = 8'(base + k);
        for (int k = 0; k < 9; k++)  eb[8*k +: 8] = 8'(base + 16 + k);
    endtask

    // Accept a command and stream 25 bytes (with one in_valid gap); ends in STORE.
    task automatic start_and_load(input logic [1:0] mode, input logic [7:0] base);
        logic [127:0] ea;
        logic [71:0]  eb;
        chk("cmd_ready_idle", cmd_ready, 1);
        chk("busy_idle", busy, 0);
        cmd_valid = 1'b1;
        cmd_mode  = mode;
        tick();
        cmd_valid = 1'b0;
        chk("in_ready_load", in_ready, 1);
        chk("cmd_ready_load", cmd_ready, 0);
        chk("busy_load", busy, 1);
        for (int i = 0; i < 25; i++) begin
            if (i == 12) begin
                in_valid = 1'b0;
                in_data  = 8'hEE;
                tick();
            end
            in_valid = 1'b1;
            in_data  = 8'(base + i);
            tick();
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        exp_flat(base, ea, eb);
        chk("in_ready_store", in_ready, 0);
        chk_act("act_store_entry", 4'b0001);
        chk("a_flat_loaded", a_flat, ea);
        chk("b_flat_loaded", b_flat, eb);
    endtask

    task automatic store_phase(input int unsigned dly, input bit stray);
        for (int d = 0; d < int'(dly); d++) begin
            if (stray) begin
                done_single = 1'b1; single_sa3 = 1'b1; single_sa2 = 1'b1;
                computation_done = 1'b1;
                set_c({4{8'hEE}});
            end
            tick();
            clear_acks();
            chk_act("act_store_hold", 4'b0001);
        end
        done_store = 1'b1;
        tick();
        done_store = 1'b0;
    endtask

    task automatic run_job(input job_t j);
        logic [127:0] ea;
        logic [71:0]  eb;
        int n;
        int p;
        int budget;
        exp_flat(j.base, ea, eb);
        start_and_load(j.mode, j.base);
        store_phase(j.ds_dly, j.stray);
        if (j.mode == 2'd0) begin
            for (int d = 0; d < 4; d++) begin
                chk_act("m0_no_run", 4'b0000);
                chk("m0_no_out", out_valid, 0);
                chk("m0_idle", cmd_ready, 1);
                done_single = 1'b1; single_sa3 = 1'b1; single_sa2 = 1'b1;
                computation_done = 1'b1;
                tick();
                clear_acks();
            end
            return;
        end
        chk_act("act_run", run_onehot(j.mode));
        for (int d = 0; d < int'(j.ack_dly); d++) begin
            if (j.stray) begin
                done_single = (j.mode != 2'd1);
                single_sa3  = (j.mode != 2'd2);
                single_sa2  = (j.mode != 2'd3);
                computation_done = 1'b1;
                set_c({4{8'hEE}});
            end
            tick();
            clear_acks();
            chk_act("act_run_hold", run_onehot(j.mode));
            chk("run_no_out", out_valid, 0);
        end
        case (j.mode)
            2'd1:    done_single = 1'b1;
            2'd2:    single_sa3  = 1'b1;
            default: single_sa2  = 1'b1;
        endcase
        if (j.cd_dly == 0) begin
            computation_done = 1'b1;
            set_c(j.c);
        end
        tick();
        clear_acks();
        if (j.cd_dly == 0) begin
            chk("skip_wait_c", out_valid, 1);
        end else begin
            chk("wait_c_no_out", out_valid, 0);
            chk_act("act_wait_c", 4'b0000);
            for (int d = 1; d < int'(j.cd_dly); d++) begin
                if (j.stray) begin
                    done_single = 1'b1; single_sa3 = 1'b1; single_sa2 = 1'b1;
                end
                tick();
                clear_acks();
                chk("wait_c_hold", out_valid, 0);
            end
            computation_done = 1'b1;
            set_c(j.c);
            tick();
            clear_acks();
        end
        n = 0;
        p = 0;
        budget = 0;
        while (n < 4 && budget < 64) begin
            chk("out_valid", out_valid, 1);
            chk("out_data", out_data, j.c[n]);
            chk("cmd_ready_out", cmd_ready, 0);
            out_ready = j.rdy_pat[p % 8];
            p++;
            tick();
            if (out_ready) n++;
            out_ready = 1'b0;
            budget++;
        end
        chk("out_count", n, 4);
        chk("out_valid_end", out_valid, 0);
        chk("busy_end", busy, 0);
        chk("cmd_ready_end", cmd_ready, 1);
        chk("err_timeout_job", err_timeout, 0);
        chk("a_flat_hold", a_flat, ea);
        chk("b_flat_hold", b_flat, eb);
    endtask

    job_t jobs[5];

    initial begin
        jobs[0] = '{mode: 2'd1, ds_dly: 3, ack_dly: 2, cd_dly: 4, base: 8'd1,
                    c: {8'd40, 8'd30, 8'd20, 8'd10}, rdy_pat: 8'hFF, stray: 1'b0};
        jobs[1] = '{mode: 2'd0, ds_dly: 1, ack_dly: 0, cd_dly: 0, base: 8'h30,
                    c: {4{8'h00}}, rdy_pat: 8'hFF, stray: 1'b0};
        jobs[2] = '{mode: 2'd2, ds_dly: 1, ack_dly: 1, cd_dly: 0, base: 8'h80,
                    c: {8'h44, 8'h33, 8'h22, 8'h11}, rdy_pat: 8'hFF, stray: 1'b1};
        jobs[3] = '{mode: 2'd3, ds_dly: 0, ack_dly: 0, cd_dly: 2, base: 8'hF0,
                    c: {8'hD4, 8'hC3, 8'hB2, 8'hA1}, rdy_pat: 8'b1001_1001, stray: 1'b1};
        jobs[4] = '{mode: 2'd1, ds_dly: 2, ack_dly: 3, cd_dly: 1, base: 8'hC8,
                    c: {8'h7F, 8'h80, 8'hFF, 8'h00}, rdy_pat: 8'b1001_1001, stray: 1'b0};

        clear_acks();
        repeat (3) tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk_act("rst_actives", 4'b0000);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_a_flat", a_flat, 0);
        chk("rst_b_flat", b_flat, 0);
        chk("rst_err", err_timeout, 0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_job(jobs[i]);
            tick();
        end

        // Reset in the middle of RUN aborts at once.
        start_and_load(2'd1, 8'h40);
        store_phase(0, 1'b0);
        chk_act("pre_rst_run", 4'b0010);
        rst = 1'b0;
        #1;
        chk_act("midrst_actives", 4'b0000);
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_a_flat", a_flat, 0);
        chk("midrst_b_flat", b_flat, 0);
        tick();
        rst = 1'b1;
        done_single = 1'b1;
        computation_done = 1'b1;
        tick();
        clear_acks();
        chk("postrst_no_out", out_valid, 0);
        chk("postrst_idle", cmd_ready, 1);

`ifdef CONV_TIMEOUT_EN
        // Watchdog: no done_store ever arrives.
        start_and_load(2'd1, 8'h60);
        repeat (TO_CYC - 1) tick();
        chk_act("to_store_hold", 4'b0001);
        chk("to_err_before", err_timeout, 0);
        tick();
        chk_act("to_store_drop", 4'b0000);
        chk("to_err_set", err_timeout, 1);
        chk("to_idle", cmd_ready, 1);
        tick();
        chk("to_err_sticky", err_timeout, 1);
        start_and_load(2'd0, 8'h70);
        chk("to_err_cleared", err_timeout, 0);
        store_phase(0, 1'b0);
        chk("to_next_idle", cmd_ready, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "time limit");
    end

endmodule
